// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single memory port.
// The instruction cache is port 0 (i) and the data cache is port 1 (d).
// A read keeps the grant until all response beats are back. A write keeps it until its data is accepted.
module mem_arbiter #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int RESP_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic [ADDR_BITS-1:0]   i_req_addr,
  input  logic                   i_req_rw,
  input  logic                   i_data_valid,
  output logic                   i_data_ready,
  input  logic [DATA_BITS-1:0]   i_data_bits,
  input  logic [DATA_BITS/8-1:0] i_data_mask,
  output logic                   i_resp_valid,
  output logic [DATA_BITS-1:0]   i_resp_data,
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic [ADDR_BITS-1:0]   d_req_addr,
  input  logic                   d_req_rw,
  input  logic                   d_data_valid,
  output logic                   d_data_ready,
  input  logic [DATA_BITS-1:0]   d_data_bits,
  input  logic [DATA_BITS/8-1:0] d_data_mask,
  output logic                   d_resp_valid,
  output logic [DATA_BITS-1:0]   d_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic                   stray_resp
);
  localparam int BEAT_BITS = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(RESP_BEATS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DATA, WAIT_RESP} state_t;

  state_t               state;
  logic                 owner;
  logic                 last;
  logic [BEAT_BITS-1:0] beat;
  logic                 data_done;

  logic sel_req_valid, sel_data_valid, fwd_data, req_ok, data_ok, resp_ok;
  logic req_fire, data_fire, grant_owner;

  always_comb begin
    sel_req_valid      = owner ? d_req_valid  : i_req_valid;
    sel_data_valid     = owner ? d_data_valid : i_data_valid;
    mem_req_addr       = owner ? d_req_addr   : i_req_addr;
    mem_req_rw         = owner ? d_req_rw     : i_req_rw;
    mem_req_data_bits  = owner ? d_data_bits  : i_data_bits;
    mem_req_data_mask  = owner ? d_data_mask  : i_data_mask;
    // data_done keeps a beat that was accepted early in GRANT from being offered again
    fwd_data           = (state == GRANT && !data_done) || state == WAIT_DATA;
    mem_req_valid      = (state == GRANT) && sel_req_valid;
    mem_req_data_valid = fwd_data && sel_data_valid;
    req_ok             = (state == GRANT) && mem_req_ready;
    data_ok            = fwd_data && mem_req_data_ready;
    resp_ok            = (state == WAIT_RESP) && mem_resp_valid;
    i_req_ready        = req_ok  && !owner;
    d_req_ready        = req_ok  &&  owner;
    i_data_ready       = data_ok && !owner;
    d_data_ready       = data_ok &&  owner;
    i_resp_valid       = resp_ok && !owner;
    d_resp_valid       = resp_ok &&  owner;
    i_resp_data        = mem_resp_data;
    d_resp_data        = mem_resp_data;
    req_fire           = mem_req_valid && mem_req_ready;
    data_fire          = mem_req_data_valid && mem_req_data_ready;
    grant_owner        = (i_req_valid && d_req_valid) ? !last : d_req_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      beat       <= '0;
      data_done  <= 1'b0;
      stray_resp <= 1'b0;
    end else begin
      if (mem_resp_valid && state != WAIT_RESP) stray_resp <= 1'b1;
      case (state)
        IDLE: if (i_req_valid || d_req_valid) begin
          owner     <= grant_owner;
          last      <= grant_owner;
          data_done <= 1'b0;
          state     <= GRANT;
        end
        GRANT: begin
          if (req_fire) begin
            data_done <= 1'b0;
            if (!mem_req_rw) begin
              beat  <= '0;
              state <= WAIT_RESP;
            end else begin
              state <= (data_fire || data_done) ? IDLE : WAIT_DATA;
            end
          end else if (data_fire) begin
            data_done <= 1'b1;
          end
        end
        WAIT_DATA: if (data_fire) state <= IDLE;
        WAIT_RESP: if (mem_resp_valid) begin
          beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
          if (beat == LAST_BEAT) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
